// File: rtl/error_injection_sequencer.sv
// error_injection_sequencer: clocked error injector for one slice [LWB..UPB]
// of a shared global error index. Supports one-shot, burst, periodic and
// sticky injection patterns.
// Optional build macro ERR_INJ_STATUS_EN adds the inj_total status counter.
module error_injection_sequencer #(
  parameter int CTRL_W = 16,
  parameter int LWB    = 0,
  parameter int UPB    = 4,
  parameter int CNT_W  = 8,
  localparam int LCL   = UPB - LWB + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              err_en,
  input  logic [CTRL_W-1:0] err_ctrl,
  input  logic [1:0]        err_mode,
  input  logic [CNT_W-1:0]  err_cnt,
  input  logic              err_arm,
  output logic [LCL-1:0]    lcl_err,
  output logic              busy,
`ifdef ERR_INJ_STATUS_EN
  output logic [15:0]       inj_total,
`endif
  output logic              done
);

  localparam int IDX_W = (LCL > 1) ? $clog2(LCL) : 1;
  localparam logic [CTRL_W-1:0] LWB_C  = CTRL_W'(LWB);
  localparam logic [CTRL_W-1:0] SPAN_C = CTRL_W'(UPB - LWB);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DONE} state_t;
  typedef enum logic [1:0] {ONESHOT, BURST, PERIODIC, STICKY} mode_t;

  state_t            state, state_n;
  mode_t             mode_q, mode_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [CNT_W-1:0]  gap, gap_n;
  logic [CNT_W-1:0]  rem, rem_n;
  logic [LCL-1:0]    lcl_n;
  logic              busy_n, done_n;
  logic [CTRL_W-1:0] offset;
  logic              in_range;

  // A single wrapped subtraction covers both bounds: below-LWB indices wrap
  // to a value larger than the slice span.
  assign offset   = err_ctrl - LWB_C;
  assign in_range = (offset <= SPAN_C);

  // Next-state and next-output decode; outputs are registered from these.
  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    idx_n   = idx;
    gap_n   = gap;
    rem_n   = rem;
    done_n  = 1'b0;
    if (!err_en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (err_arm) begin
            if (in_range) begin
              state_n = ACTIVE;
              mode_n  = mode_t'(err_mode);
              idx_n   = offset[IDX_W-1:0];
              gap_n   = err_cnt;
              rem_n   = (mode_t'(err_mode) == BURST && err_cnt != '0)
                        ? err_cnt - CNT_W'(1) : '0;
            end else begin
              done_n = 1'b1;
            end
          end
        end
        ACTIVE: begin
          case (mode_q)
            ONESHOT: state_n = DONE;
            BURST: begin
              if (rem == '0) state_n = DONE;
              else           rem_n   = rem - CNT_W'(1);
            end
            PERIODIC: begin
              if (gap != '0) begin
                state_n = GAP;
                rem_n   = gap - CNT_W'(1);
              end
            end
            default: state_n = ACTIVE;
          endcase
        end
        GAP: begin
          if (rem == '0) state_n = ACTIVE;
          else           rem_n   = rem - CNT_W'(1);
        end
        default: state_n = IDLE;
      endcase
    end
    lcl_n = '0;
    if (state_n == ACTIVE) lcl_n[idx_n] = 1'b1;
    busy_n = (state_n == ACTIVE) || (state_n == GAP);
    done_n = done_n || (state_n == DONE);
  end

  // State, latched transaction fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mode_q  <= ONESHOT;
      idx     <= '0;
      gap     <= '0;
      rem     <= '0;
      lcl_err <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      mode_q  <= mode_n;
      idx     <= idx_n;
      gap     <= gap_n;
      rem     <= rem_n;
      lcl_err <= lcl_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

`ifdef ERR_INJ_STATUS_EN
  // Saturating count of cycles with any local error asserted; abort keeps it.
  always_ff @(posedge clk) begin
    if (rst) inj_total <= '0;
    else if ((|lcl_err) && (inj_total != 16'hFFFF)) inj_total <= inj_total + 16'd1;
  end
`endif

endmodule
